// File: rtl/reu_pkg.sv
// reu_pkg: shared arbiter state encoding, default sizes and the open-bus read value
package reu_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_SLOT, ARB_GAP} arb_state_t;
  localparam int SLOT_LEN_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int RAM_AW = 25;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
endpackage

// File: rtl/reu_rr_pick.sv
// reu_rr_pick: two-way round-robin selector; on a tie the port that did not win last time is chosen
module reu_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);
  assign valid = |req;
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/reu_ram_arbiter.sv
// reu_ram_arbiter: round-robin sharing of the SDRAM port between the REU (port 0) and cartridge (port 1)
// with fixed SLOT_LEN cycle windows; define RAM_TIMEOUT_EN to add the ISSUE watchdog and timeout_err flag.
module reu_ram_arbiter
  import reu_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int SLOT_LEN = SLOT_LEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [7:0]    dout0,
  input  logic          we0,
  output logic          cycle0,
  output logic [7:0]    din0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    dout1,
  input  logic          we1,
  output logic          cycle1,
  output logic [7:0]    din1,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_dout,
  input  logic          mem_ack,
  input  logic [7:0]    mem_din,
  output logic          busy,
  output logic          timeout_err
);
  localparam int CW = $clog2(SLOT_LEN);
  arb_state_t state, state_nx;
  logic gnt, last, pick_valid, pick_gnt, expired, done, din_ld;
  logic [CW-1:0] cnt;
  logic [7:0] din_val;

  if (SLOT_LEN < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("reu_ram_arbiter: SLOT_LEN must be >= 2 and TIMEOUT >= 1");
  end

  reu_rr_pick u_pick (
    .req  ({req1, req0}),
    .last (last),
    .valid(pick_valid),
    .gnt  (pick_gnt)
  );

`ifdef RAM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd <= state != ARB_ISSUE ? '0 : wd == WW'(TIMEOUT) ? wd : wd + 1'b1;
      if (expired) timeout_err <= 1'b1;
    end
  end
  // a late ack in the expiry clock still wins and returns real data
  assign expired = state == ARB_ISSUE && !mem_ack && wd == WW'(TIMEOUT - 1);
`else
  assign expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = mem_ack || expired;
  assign din_ld = state == ARB_ISSUE && done && (expired || !mem_we);
  assign din_val = expired ? OPEN_BUS : mem_din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state == ARB_IDLE  ? (pick_valid ? ARB_ISSUE : ARB_IDLE) :
               state == ARB_ISSUE ? (done ? ARB_SLOT : ARB_ISSUE) :
               state == ARB_SLOT  ? (cnt == '0 ? ARB_GAP : ARB_SLOT) : ARB_IDLE;
    mem_req = state == ARB_ISSUE;
    busy = state != ARB_IDLE;
    cycle0 = state == ARB_SLOT && !gnt;
    cycle1 = state == ARB_SLOT && gnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_dout <= '0;
      din0 <= '0;
      din1 <= '0;
    end else begin
      if (state == ARB_IDLE && pick_valid) begin
        gnt <= pick_gnt;
        last <= pick_gnt;
        mem_addr <= pick_gnt ? addr1 : addr0;
        mem_we <= pick_gnt ? we1 : we0;
        mem_dout <= pick_gnt ? dout1 : dout0;
      end
      if (state == ARB_ISSUE && done) cnt <= CW'(SLOT_LEN - 1);
      if (state == ARB_SLOT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) mem_we <= 1'b0;
      end
      if (din_ld && !gnt) din0 <= din_val;
      if (din_ld && gnt) din1 <= din_val;
    end
  end
endmodule

// File: tb/tb_reu_ram_arbiter.sv
// tb_reu_ram_arbiter: stimulus queues expected accesses; a monitor checks each completed cycle window
module tb_reu_ram_arbiter;
  localparam int AW = 25;
  localparam int TO = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0] dout0 = '0, dout1 = '0, mem_din = '0;
  logic cycle0, cycle1, mem_req, mem_we, busy, timeout_err;
  logic [7:0] din0, din1, mem_dout;
  logic [AW-1:0] mem_addr;

  reu_ram_arbiter #(.AW(AW), .SLOT_LEN(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .dout0(dout0), .we0(we0), .cycle0(cycle0), .din0(din0),
    .req1(req1), .addr1(addr1), .dout1(dout1), .we1(we1), .cycle1(cycle1), .din1(din1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
    .mem_ack(mem_ack), .mem_din(mem_din), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit port;
    logic [AW-1:0] addr;
    bit we;
    logic [7:0] dout, din, din_other;
    int req_len, spacing;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, done_cnt = 0, ack_lat = 1;
  logic [7:0] m_din [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_acc(bit p, logic [AW-1:0] a, bit w, logic [7:0] d, logic [7:0] rd,
                                     int rlen, int sp);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.we = w;
    e.dout = d;
    e.din = w ? m_din[p] : rd;
    e.din_other = m_din[!p];
    e.req_len = rlen;
    e.spacing = sp;
    q.push_back(e);
    if (!w) m_din[p] = rd;
  endfunction

  // SDRAM controller model: ack in the ack_lat-th clock of mem_req (0 = never); data = addr[7:0] + 8'h82
  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        n++;
        mem_ack = (n == ack_lat);
        mem_din = mem_addr[7:0] + 8'h82;
      end else begin
        n = 0;
        mem_ack = 1'b0;
      end
    end
  end

  int rq_n = 0, sl_n = 0, cyc = 0, start = 0, prev_start = 0;
  logic [AW-1:0] c_addr;
  logic c_we, s_port;
  logic [7:0] c_dout, s_din;
  bit hold_bad = 0, din_bad = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rq_n = 0;
        sl_n = 0;
        hold_bad = 0;
        din_bad = 0;
      end else begin
        if (mem_req) begin
          if (rq_n == 0) begin
            c_addr = mem_addr;
            c_we = mem_we;
            c_dout = mem_dout;
          end else if (mem_addr !== c_addr || mem_we !== c_we || mem_dout !== c_dout) hold_bad = 1;
          rq_n++;
        end
        if (cycle0 || cycle1) begin
          if (sl_n == 0) begin
            s_port = cycle1;
            s_din = cycle1 ? din1 : din0;
            start = cyc;
          end else if ((s_port ? din1 : din0) !== s_din || cycle1 !== s_port) din_bad = 1;
          if (cycle0 && cycle1) din_bad = 1;
          sl_n++;
        end else if (sl_n != 0) begin
          if (q.size() == 0) chk("unexpected_window", 1, 0);
          else begin
            e = q.pop_front();
            chk("grant_port", s_port, e.port);
            chk("mem_addr", c_addr, e.addr);
            chk("mem_we", c_we, e.we);
            chk("mem_dout", c_dout, e.dout);
            chk("req_len", rq_n, e.req_len);
            chk("slot_len", sl_n, 4);
            chk("din", s_din, e.din);
            chk("din_other", s_port ? din0 : din1, e.din_other);
            chk("din_stable", din_bad, 0);
            chk("req_hold", hold_bad, 0);
            chk("we_cleared", mem_we, 0);
            if (e.spacing != 0) chk("spacing", start - prev_start, e.spacing);
          end
          prev_start = start;
          done_cnt++;
          rq_n = 0;
          sl_n = 0;
          hold_bad = 0;
          din_bad = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 400) begin
      tick();
      k++;
    end
    if (done_cnt < n) chk("window_timeout", done_cnt, n);
  endtask

  task automatic drive(bit p, logic [AW-1:0] a, bit w, logic [7:0] d);
    if (p) begin
      addr1 = a; we1 = w; dout1 = d; req1 = 1'b1;
    end else begin
      addr0 = a; we0 = w; dout0 = d; req0 = 1'b1;
    end
  endtask

  task automatic access(bit p, logic [AW-1:0] a, bit w, logic [7:0] d, logic [7:0] rd, int lat);
    int n;
    n = done_cnt + 1;
    ack_lat = lat;
    expect_acc(p, a, w, d, rd, lat == 0 ? TO : lat, 0);
    drive(p, a, w, d);
    wait_done(n);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, k;
    m_din[0] = 8'h00;
    m_din[1] = 8'h00;
    tick(); tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cycle", {cycle1, cycle0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we_dout", {mem_we, mem_dout}, 0);
    chk("rst_din", {din1, din0}, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_no_req", busy, 0);
    // single read, ack in third ISSUE clock
    access(0, 25'h1000123, 0, 8'h00, 8'hA5, 3);
    // single write on port 1
    access(1, 25'h0000456, 1, 8'h3C, 8'h00, 1);
    chk("din1_after_write", din1, 8'h00);
    // contention: both held for six accesses, strict alternation at SLOT_LEN+3 spacing
    ack_lat = 1;
    n = done_cnt + 6;
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) expect_acc(0, 25'h0000010, 0, 8'h00, 8'h92, 1, i == 0 ? 0 : 7);
      else expect_acc(1, 25'h1ABCDEF, 1, 8'h77, 8'h00, 1, 7);
    drive(0, 25'h0000010, 0, 8'h00);
    drive(1, 25'h1ABCDEF, 1, 8'h77);
    wait_done(n);
    req0 = 1'b0;
    req1 = 1'b0;
    // inputs changed during the slot must not disturb the latched access
    n = done_cnt + 1;
    expect_acc(0, 25'h0000040, 1, 8'h11, 8'h00, 1, 0);
    drive(0, 25'h0000040, 1, 8'h11);
    k = 0;
    while (!cycle0 && k < 50) begin
      tick();
      k++;
    end
    chk("t4_reach_slot", cycle0, 1);
    addr0 = 25'h0000050;
    dout0 = 8'h22;
    tick();
    chk("t4_addr_held", mem_addr, 25'h0000040);
    chk("t4_dout_held", mem_dout, 8'h11);
    wait_done(n);
    req0 = 1'b0;
    access(0, 25'h0000050, 1, 8'h22, 8'h00, 1);
`ifdef RAM_TIMEOUT_EN
    access(0, 25'h0000077, 0, 8'h00, 8'hFF, 0);
    chk("timeout_err_set", timeout_err, 1);
    access(1, 25'h0000088, 0, 8'h00, 8'h0A, 2);
    chk("timeout_err_sticky", timeout_err, 1);
`else
    chk("timeout_err_tied", timeout_err, 0);
`endif
    // reset while ISSUE is pending: outputs drop without a clock edge
    n = done_cnt;
    ack_lat = 0;
    drive(0, 25'h0000123, 0, 8'h00);
    k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    chk("t5_in_issue", mem_req, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_mem_req_async", mem_req, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_cycle_async", {cycle1, cycle0}, 0);
    chk("t5_mem_addr_async", mem_addr, 0);
    req0 = 1'b0;
    tick(); tick();
    chk("t5_no_window", done_cnt, n);
    m_din[0] = 8'h00;
    m_din[1] = 8'h00;
    reset_n = 1'b1;
    tick();
    chk("t5_timeout_err_cleared", timeout_err, 0);
    ack_lat = 1;
    expect_acc(0, 25'h0000200, 0, 8'h00, 8'h82, 1, 0);
    drive(0, 25'h0000200, 0, 8'h00);
    drive(1, 25'h0000300, 0, 8'h00);
    wait_done(n + 1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick(); tick(); tick();
    chk("queue_empty", q.size(), 0);
    chk("idle_at_end", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
